// File: rtl/instruction_memory.sv
// Word-addressed instruction store with a combinational fetch port and a
// single-cycle program-write port; reset restores the built-in boot image.
module instruction_memory #(
    parameter int          DEPTH      = 256,
    parameter logic [31:0] RESET_FILL = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    output logic [31:0] instr,
    output logic        misaligned,
    output logic        addr_err,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_data
);

    localparam int          IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH) << 2;

    typedef logic [31:0] mem_t [DEPTH];

    // Boot image: four fixed words, everything else the fill value.
    localparam mem_t DEFAULT_IMAGE = '{
        0:       32'hF0F0_A5A5,
        1:       32'h0000_0000,
        2:       32'hFF00_FF00,
        3:       32'h00FF_00FF,
        default: RESET_FILL
    };

    // Contents are valid from time zero, before any clock or reset.
    mem_t mem_q = DEFAULT_IMAGE;
    mem_t mem_d;

    logic             rd_in_range;
    logic             wr_in_range;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             unused_prog_low;

    assign rd_in_range     = ({1'b0, addr} < BYTE_LIMIT);
    assign wr_in_range     = ({1'b0, prog_addr} < BYTE_LIMIT);
    assign rd_idx          = addr[IDX_W+1:2];
    assign wr_idx          = prog_addr[IDX_W+1:2];
    assign unused_prog_low = ^prog_addr[1:0];

    // Fetch path has no registers: outputs track addr and the current contents.
    always_comb begin
        instr      = RESET_FILL;
        misaligned = (addr[1:0] != 2'b00);
        addr_err   = !rd_in_range;
        if (rd_in_range) begin
            instr = mem_q[rd_idx];
        end
    end

    // No handshake: a write with prog_we high lands on the next rising edge.
    always_comb begin
        mem_d = mem_q;
        if (prog_we && wr_in_range) begin
            mem_d[wr_idx] = prog_data;
        end
    end

    // Reset wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= DEFAULT_IMAGE;
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: tb/tb_instruction_memory.sv
// Bench for instruction_memory: scoreboard queue fed by stimulus, drained by a
// monitor, with a word-array reference model built from the memory rules.
module tb_instruction_memory;

    localparam int          DEPTH      = 256;
    localparam logic [31:0] RESET_FILL = 32'h0000_0013;
    localparam logic [31:0] LIMIT      = 32'(DEPTH * 4);

    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] instr;
    logic        misaligned;
    logic        addr_err;
    logic        prog_we = 1'b0;
    logic [31:0] prog_addr = 32'h0;
    logic [31:0] prog_data = 32'h0;

    logic [31:0] ref_mem [DEPTH];
    logic [33:0] exp_q [$];
    string       name_q [$];
    event        sample_ev;
    int          checks = 0;
    int          errors = 0;

    instruction_memory #(.DEPTH(DEPTH), .RESET_FILL(RESET_FILL)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .instr      (instr),
        .misaligned (misaligned),
        .addr_err   (addr_err),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data)
    );

    // Clock only starts once the no-clock checks are done.
    initial begin
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    function automatic void ref_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = RESET_FILL;
        ref_mem[0] = 32'hF0F0_A5A5;
        ref_mem[1] = 32'h0000_0000;
        ref_mem[2] = 32'hFF00_FF00;
        ref_mem[3] = 32'h00FF_00FF;
    endfunction

    function automatic logic [33:0] ref_read(input logic [31:0] a);
        logic [31:0] w;
        w = (a >= LIMIT) ? RESET_FILL : ref_mem[a / 4];
        return {w, (a % 4) != 0, a >= LIMIT};
    endfunction

    task automatic expect_now(input string nm);
        exp_q.push_back(ref_read(addr));
        name_q.push_back(nm);
        -> sample_ev;
        #2;
    endtask

    // One clock cycle: inputs at negedge, check before and after the edge.
    task automatic step(input logic r, input logic we, input logic [31:0] pa,
                        input logic [31:0] pd, input logic [31:0] ra, input string nm);
        @(negedge clk);
        rst = r; prog_we = we; prog_addr = pa; prog_data = pd; addr = ra;
        #1;
        expect_now({nm, "_pre"});
        @(posedge clk);
        if (r) ref_reset();
        else if (we && pa < LIMIT) ref_mem[pa / 4] = pd;
        #1;
        expect_now({nm, "_post"});
    endtask

    // Monitor: sample outputs shortly after each request and compare.
    initial begin
        logic [33:0] e;
        string nm;
        forever begin
            @(sample_ev);
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sample: queue empty at instr=%h", instr);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if ({instr, misaligned, addr_err} !== e) begin
                    errors++;
                    $display("FAIL %s addr=%h: got instr=%h mis=%b err=%b, want instr=%h mis=%b err=%b",
                             nm, addr, instr, misaligned, addr_err, e[33:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        logic [31:0] pa, ra, pd;
        logic        r, we;
        ref_reset();

        // Fetches with no clock and no reset ever applied.
        addr = 32'h0;   #5; expect_now("boot_w0");
        addr = 32'h8;   #3; expect_now("boot_w2");
        addr = 32'hA;   #3; expect_now("misaligned_w2");
        addr = 32'h400; #3; expect_now("out_of_range");
        addr = 32'h403; #3; expect_now("both_flags");
        addr = 32'h3FC; #3; expect_now("last_word");
        addr = 32'h4;   #3; expect_now("boot_w1");
        addr = 32'hD;   #3; expect_now("boot_w3_mis");
        if (ref_read(32'h0) !== {32'hF0F0_A5A5, 1'b0, 1'b0} ||
            ref_read(32'h400) !== {RESET_FILL, 1'b0, 1'b1}) begin
            $display("FAIL model_sanity: reference image disagrees with boot constants");
            errors++;
        end
        checks++;

        clk_run = 1'b1;
        step(1'b0, 1'b1, 32'h8,   32'h1234_5678, 32'h8, "write_w2");
        step(1'b1, 1'b0, 32'h0,   32'h0,         32'h8, "reset_w2");
        step(1'b1, 1'b1, 32'h0,   32'hDEAD_BEEF, 32'h0, "rst_beats_we");
        step(1'b0, 1'b0, 32'h0,   32'h0,         32'h0, "after_rst_we");
        step(1'b0, 1'b1, 32'h7,   32'hAAAA_5555, 32'h4, "low_bits_ignored");
        step(1'b0, 1'b1, 32'h400, 32'h5555_AAAA, 32'h400, "oor_write");
        step(1'b0, 1'b1, 32'h3FC, 32'hCAFE_0001, 32'h3FC, "write_last");
        step(1'b0, 1'b1, 32'h3FC, 32'hCAFE_0002, 32'h3FE, "back_to_back");
        step(1'b0, 1'b1, 32'h10,  32'h0BAD_F00D, 32'h3FC, "prog_seq");
        step(1'b1, 1'b0, 32'h0,   32'h0,         32'h10, "rst_mid_seq");
        step(1'b0, 1'b0, 32'h0,   32'h0,         32'h3FC, "seq_discarded");

        // Randomised traffic: mixes in-range, out-of-range, resets and RAW on the same word.
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 19) == 0);
            we = ($urandom_range(0, 1) == 1);
            pd = $urandom;
            case ($urandom_range(0, 5))
                0:       pa = $urandom;
                1:       pa = LIMIT + 32'($urandom_range(0, 15));
                2:       pa = 32'($urandom_range(0, 15));
                default: pa = 32'($urandom_range(0, DEPTH * 4 - 1));
            endcase
            case ($urandom_range(0, 4))
                0:       ra = pa;
                1:       ra = $urandom;
                2:       ra = 32'($urandom_range(0, 15));
                default: ra = 32'($urandom_range(0, DEPTH * 4 + 7));
            endcase
            step(r, we, pa, pd, ra, "random");
        end

        @(negedge clk);
        rst = 1'b0; prog_we = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected responses never sampled, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_memory.md
INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit instruction words held.
REQ-002 Parameter RESET_FILL, default 32'h0000_0013, value of every word not listed in REQ-011 after reset (RISC-V NOP).
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port addr  input  32  byte address of the instruction to fetch.
REQ-006 Port instr  output  32  instruction word at addr.
REQ-007 Port misaligned  output  1  high when addr[1:0] != 0.
REQ-008 Port addr_err  output  1  high when addr >= DEPTH*4.
REQ-009 Port prog_we  input  1  program-write enable.
REQ-010 Port prog_addr  input  32  byte address of the program write; prog_data  input  32  word to write.

Function
REQ-011 The default image SHALL be: word 0 = 32'hF0F0_A5A5, word 1 = 32'h0000_0000, word 2 = 32'hFF00_FF00, word 3 = 32'h00FF_00FF, all other words = RESET_FILL.
REQ-012 Storage SHALL hold the default image from time zero (initialised contents), with no clock edge or reset required before the first read.
REQ-013 Word index SHALL be addr[31:2], so addr 0x0 selects word 0 and addr 0x8 selects word 2.
REQ-014 The read path SHALL be combinational: instr, misaligned and addr_err follow addr within the same cycle, with no clock edge.
REQ-015 A misaligned addr SHALL ignore addr[1:0], return the word at addr[31:2], and assert misaligned.
REQ-016 When addr >= DEPTH*4, instr SHALL be RESET_FILL and addr_err SHALL be 1; otherwise addr_err SHALL be 0.
REQ-017 Misaligned and out-of-range conditions SHALL be independent; both flags may be high together.
REQ-018 On a rising edge with rst=0, prog_we=1 and prog_addr < DEPTH*4, prog_data SHALL be written to word prog_addr[31:2].
REQ-019 prog_addr[1:0] SHALL be ignored on writes.
REQ-020 Out-of-range writes SHALL be dropped with no state change.
REQ-021 Read during write to the same word: instr SHALL show the old word before the edge and the new word immediately after it.
REQ-022 Write latency SHALL be 1 edge; no handshake, and back-to-back writes are allowed every cycle.

Reset
REQ-023 On a rising edge with rst=1, every word SHALL be restored to the default image of REQ-011.
REQ-024 rst SHALL take priority over prog_we in the same cycle, and the write SHALL be discarded.
REQ-025 Outputs SHALL have no registers of their own; during and after reset they SHALL reflect the restored image at the current addr.
REQ-026 Asserting rst mid-program sequence SHALL discard all prior writes.

Verification
REQ-027 No clock, no reset; addr=0x0, wait 5 ns -> instr=F0F0A5A5, misaligned=0, addr_err=0.
REQ-028 No clock; addr=0x8 -> instr=FF00FF00.
REQ-029 addr=0xA -> instr=FF00FF00, misaligned=1.
REQ-030 addr=0x400 (DEPTH=256) -> instr=00000013, addr_err=1.
REQ-031 Write 0x12345678 to prog_addr=0x8, then read addr=0x8 -> instr=12345678 after the edge; apply rst for one edge -> instr=FF00FF00.
REQ-032 rst=1 and prog_we=1 in the same cycle to prog_addr=0x0 -> word 0 stays F0F0A5A5.
